vga_timing_gen: RTL

Parametrised VGA raster engine. It is the successor to the fixed 640x480 vga block and generalises resolution, porches, sync polarity, pixel-clock divide and colour width. It derives a pixel clock from clk_in, runs the horizontal and vertical counters, requests pixels from an upstream source by coordinate, and drives registered sync, data-enable and RGB to the DAC or pins. It sits between a frame-buffer or pattern source and the video connector.

---
 rtl/vga_timing_gen.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster engine.
// Builds a pixel clock from clk_in, runs the horizontal and vertical raster
// counters, requests pixels by coordinate (stage 1), and drives registered
// sync, data-enable and RGB one pixel later (stage 2).
// Optional macro VGA_TEST_PATTERN_EN adds a pattern_on input that replaces
// rgb_in with 8 vertical colour bars.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int CLK_DIV  = 2,
  parameter int COLOR_W  = 8
) (
  input  logic                     clk_in,
  input  logic                     rst,
  input  logic                     enable,
`ifdef VGA_TEST_PATTERN_EN
  input  logic                     pattern_on,
`endif
  input  logic [3*COLOR_W-1:0]     rgb_in,
  output logic                     pix_req,
  output logic [$clog2(H_ACTIVE+H_FP+H_SYNC+H_BP)-1:0] pix_x,
  output logic [$clog2(V_ACTIVE+V_FP+V_SYNC+V_BP)-1:0] pix_y,
  output logic                     clk_out,
  output logic [COLOR_W-1:0]       r,
  output logic [COLOR_W-1:0]       g,
  output logic [COLOR_W-1:0]       b,
  output logic                     h_sync,
  output logic                     v_sync,
  output logic                     de,
  output logic                     frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int XW      = $clog2(H_TOTAL);
  localparam int YW      = $clog2(V_TOTAL);
  localparam int DW      = $clog2(CLK_DIV);

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);

  localparam logic [XW-1:0] H_LAST  = XW'(H_TOTAL - 1);
  localparam logic [XW-1:0] H_ACT_C = XW'(H_ACTIVE);
  localparam logic [XW-1:0] HS_BEG  = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0] HS_END  = XW'(H_ACTIVE + H_FP + H_SYNC - 1);

  localparam logic [YW-1:0] V_LAST  = YW'(V_TOTAL - 1);
  localparam logic [YW-1:0] V_ACT_C = YW'(V_ACTIVE);
  localparam logic [YW-1:0] VS_BEG  = YW'(V_ACTIVE + V_FP);
  localparam logic [YW-1:0] VS_END  = YW'(V_ACTIVE + V_FP + V_SYNC - 1);

  localparam logic HS_LVL = (HS_POL != 0);
  localparam logic VS_LVL = (VS_POL != 0);

  // Parameter sanity checks at elaboration time
  if (CLK_DIV < 2 || (CLK_DIV % 2) != 0) begin : g_bad_div
    $error("vga_timing_gen: CLK_DIV must be even and >= 2");
  end
  if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_timing
    $error("vga_timing_gen: timing parameters must be non-zero");
  end

  logic [DW-1:0] div_cnt;
  logic [DW-1:0] div_nxt;
  logic          tick;
  logic [XW-1:0] h_cnt;
  logic [YW-1:0] v_cnt;
  logic          h_wrap;
  logic          v_wrap;
  logic          hs_active;
  logic          vs_active;
  logic [3*COLOR_W-1:0] px_rgb;

  // Divider phase, pixel tick and sync windows decoded from stage-1 position
  always_comb begin
    tick      = enable && (div_cnt == DIV_LAST);
    div_nxt   = tick ? '0 : div_cnt + DW'(1);
    h_wrap    = (h_cnt == H_LAST);
    v_wrap    = (v_cnt == V_LAST);
    hs_active = (pix_x >= HS_BEG) && (pix_x <= HS_END);
    vs_active = (pix_y >= VS_BEG) && (pix_y <= VS_END);
  end

`ifdef VGA_TEST_PATTERN_EN
  localparam int BAR_W = H_ACTIVE / 8;
  if (BAR_W == 0) begin : g_bad_bar
    $error("vga_timing_gen: H_ACTIVE must be >= 8 for the test pattern");
  end
  localparam logic [XW-1:0] BAR_W_C = XW'(BAR_W);
  logic [XW-1:0] bar_k;

  // Colour source: upstream pixel or bar colour derived from requested column
  always_comb begin
    bar_k  = pix_x / BAR_W_C;
    px_rgb = rgb_in;
    if (pattern_on) begin
      px_rgb = {{COLOR_W{bar_k[2]}}, {COLOR_W{bar_k[1]}}, {COLOR_W{bar_k[0]}}};
    end
  end
`else
  // Colour source: upstream pixel passed straight through
  always_comb begin
    px_rgb = rgb_in;
  end
`endif

  // Pixel-clock divider; clk_out tracks the phase that div_cnt is about to take
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      clk_out <= 1'b0;
    end else if (enable) begin
      div_cnt <= div_nxt;
      clk_out <= (div_nxt >= DIV_HALF);
    end
  end

  // Raster counters and both output stages, all advancing on the pixel tick
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      pix_req     <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      de          <= 1'b0;
      r           <= '0;
      g           <= '0;
      b           <= '0;
      h_sync      <= ~HS_LVL;
      v_sync      <= ~VS_LVL;
      frame_start <= 1'b0;
    end else begin
      frame_start <= tick && (h_cnt == '0) && (v_cnt == '0);
      if (tick) begin
        h_cnt <= h_wrap ? '0 : h_cnt + XW'(1);
        if (h_wrap) begin
          v_cnt <= v_wrap ? '0 : v_cnt + YW'(1);
        end
        pix_x   <= h_cnt;
        pix_y   <= v_cnt;
        pix_req <= (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
        de      <= pix_req;
        {r, g, b} <= pix_req ? px_rgb : '0;
        h_sync  <= hs_active ? HS_LVL : ~HS_LVL;
        v_sync  <= vs_active ? VS_LVL : ~VS_LVL;
      end
    end
  end

endmodule
